// File: rtl/aes_spi_pkg.sv
// aes_spi_pkg: shared types and constants for the AES-over-SPI job sequencer.
//   seq_state_t  - sequencer FSM states
//   KS_*         - cmd_ksize codes
//   ERR_*        - err_code values
//   TEXT_BYTES   - bytes in one AES block (text and result)
//   key_bytes()  - key length in bytes for a ksize code (0 for the illegal code)
package aes_spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_ISSUE,
    S_TX_WAIT,
    S_RES_WAIT,
    S_RX_ISSUE,
    S_RX_WAIT,
    S_DONE,
    S_ERR
  } seq_state_t;

  localparam logic [1:0] KS_128     = 2'b00;
  localparam logic [1:0] KS_192     = 2'b01;
  localparam logic [1:0] KS_256     = 2'b10;
  localparam logic [1:0] KS_ILLEGAL = 2'b11;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_KSIZE   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam int unsigned TEXT_BYTES = 16;

  function automatic logic [7:0] key_bytes(input logic [1:0] ksize);
    case (ksize)
      KS_128:  return 8'd16;
      KS_192:  return 8'd24;
      KS_256:  return 8'd32;
      default: return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/aes_spi_sequencer_seq_timer.sv
// seq_timer: clearable, enableable up-counter used as the sequencer's
// wait-state watchdog.
//   clk, reset  - clock, synchronous active-low reset
//   clr         - force the count to zero (has priority over en)
//   en          - count one per cycle
//   expired     - high in the cycle where the TIMEOUT_CYCLES-th enabled
//                 cycle completes, so the owner leaves on that edge
module seq_timer
  #(parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned TW             = 13)
  (input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired);

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + TW'(1);
    end
  end

  assign expired = en && (count == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/aes_spi_sequencer.sv
// aes_spi_sequencer: runs one AES job over the SPI master. Sends
// text[15..0], the key-length byte and key[KB-1..0] one byte per transfer,
// waits for the slave's result flag, then reads 16 result bytes back.
//   clk, reset         - clock, synchronous active-low reset
//   cmd_valid/ready    - host job handshake (ready only in IDLE)
//   cmd_dec/ksize/text/key - job parameters, latched on accept
//   dec_sel            - latched cmd_dec for the whole job
//   m_start/m_tx       - one-cycle transfer request and its byte
//   m_busy/m_done/m_rx - SPI master status and received byte
//   s_res_ready        - AES slave result available
//   res_valid/res_data - job completion pulse and 128-bit result
//   err/err_code       - error pulse and sticky code (01 ksize, 10 timeout)
module aes_spi_sequencer
  import aes_spi_pkg::*;
  #(parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned TW             = 13)
  (input  logic         clk,
   input  logic         reset,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic         cmd_dec,
   input  logic [1:0]   cmd_ksize,
   input  logic [127:0] cmd_text,
   input  logic [255:0] cmd_key,
   output logic         dec_sel,
   output logic         m_start,
   output logic [7:0]   m_tx,
   input  logic         m_busy,
   input  logic         m_done,
   input  logic [7:0]   m_rx,
   input  logic         s_res_ready,
   output logic         res_valid,
   output logic [127:0] res_data,
   output logic         err,
   output logic [1:0]   err_code);

  seq_state_t     state;
  logic [5:0]     idx;
  logic [127:0]   text_r;
  logic [255:0]   key_r;
  logic [7:0]     kb_r;
  logic [5:0]     tx_last;
  logic [3:0]     tsel;
  logic [4:0]     ksel;
  logic [7:0]     frame_byte;
  logic           tmr_en;
  logic           tmr_clr;
  logic           tmr_exp;

  // Index of the final frame byte: TX_LEN-1 = 16 + KB.
  assign tx_last = kb_r[5:0] + 6'(TEXT_BYTES);

  // Frame byte for the current idx. tsel maps idx 0..15 onto text/result
  // byte 15..0. ksel maps idx 17.. onto key byte KB-1..0; 5-bit wraparound
  // keeps KB+16-idx exact for all three key lengths.
  always_comb begin
    tsel = 4'd15 - idx[3:0];
    ksel = kb_r[4:0] + 5'd16 - idx[4:0];
    if (idx < 6'(TEXT_BYTES)) begin
      frame_byte = text_r[{tsel, 3'b000} +: 8];
    end else if (idx == 6'(TEXT_BYTES)) begin
      frame_byte = kb_r;
    end else begin
      frame_byte = key_r[{ksel, 3'b000} +: 8];
    end
  end

  // The watchdog restarts on every state entry: it is held clear outside
  // the wait states and on any cycle in which a wait state is being left.
  always_comb begin
    tmr_en  = (state == S_TX_WAIT) || (state == S_RX_WAIT) ||
              (state == S_RES_WAIT);
    tmr_clr = !tmr_en || tmr_exp ||
              (m_done && (state != S_RES_WAIT)) ||
              ((state == S_RES_WAIT) && s_res_ready);
  end

  seq_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TW            (TW)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(tmr_exp)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      idx       <= '0;
      text_r    <= '0;
      key_r     <= '0;
      kb_r      <= '0;
      dec_sel   <= 1'b0;
      m_start   <= 1'b0;
      m_tx      <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      m_start   <= 1'b0;
      res_valid <= 1'b0;
      err       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            dec_sel   <= cmd_dec;
            text_r    <= cmd_text;
            key_r     <= cmd_key;
            kb_r      <= key_bytes(cmd_ksize);
            idx       <= '0;
            cmd_ready <= 1'b0;
            if (cmd_ksize == KS_ILLEGAL) begin
              state    <= S_ERR;
              err      <= 1'b1;
              err_code <= ERR_KSIZE;
            end else begin
              state    <= S_TX_ISSUE;
              err_code <= ERR_NONE;
            end
          end
        end

        S_TX_ISSUE: begin
          if (!m_busy) begin
            m_start <= 1'b1;
            m_tx    <= frame_byte;
            state   <= S_TX_WAIT;
          end
        end

        // m_done is tested before the watchdog so a completion landing on
        // the expiry cycle still counts.
        S_TX_WAIT: begin
          if (m_done) begin
            idx   <= idx + 6'd1;
            state <= (idx == tx_last) ? S_RES_WAIT : S_TX_ISSUE;
          end else if (tmr_exp) begin
            state    <= S_ERR;
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
          end
        end

        S_RES_WAIT: begin
          if (s_res_ready) begin
            idx   <= '0;
            state <= S_RX_ISSUE;
          end else if (tmr_exp) begin
            state    <= S_ERR;
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
          end
        end

        S_RX_ISSUE: begin
          m_start <= 1'b1;
          m_tx    <= '0;
          state   <= S_RX_WAIT;
        end

        S_RX_WAIT: begin
          if (m_done) begin
            res_data[{tsel, 3'b000} +: 8] <= m_rx;
            idx <= idx + 6'd1;
            if (idx == 6'(TEXT_BYTES - 1)) begin
              state     <= S_DONE;
              res_valid <= 1'b1;
            end else begin
              state <= S_RX_ISSUE;
            end
          end else if (tmr_exp) begin
            state    <= S_ERR;
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
          end
        end

        S_DONE, S_ERR: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
        end

        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_spi_sequencer.sv
// Self-checking bench for aes_spi_sequencer: a behavioural SPI master plus
// AES slave drives the DUT; the expected byte stream, result and error code
// of each job are built from the frame rules and compared on every cycle.
module tb_aes_spi_sequencer;

  localparam int unsigned TMO = 300;

  logic         clk;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_dec;
  logic [1:0]   cmd_ksize;
  logic [127:0] cmd_text;
  logic [255:0] cmd_key;
  logic         dec_sel;
  logic         m_start;
  logic [7:0]   m_tx;
  logic         m_busy;
  logic         m_done;
  logic [7:0]   m_rx;
  logic         s_res_ready;
  logic         res_valid;
  logic [127:0] res_data;
  logic         err;
  logic [1:0]   err_code;

  aes_spi_sequencer #(
    .TIMEOUT_CYCLES(TMO),
    .TW            (13)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dec    (cmd_dec),
    .cmd_ksize  (cmd_ksize),
    .cmd_text   (cmd_text),
    .cmd_key    (cmd_key),
    .dec_sel    (dec_sel),
    .m_start    (m_start),
    .m_tx       (m_tx),
    .m_busy     (m_busy),
    .m_done     (m_done),
    .m_rx       (m_rx),
    .s_res_ready(s_res_ready),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .err        (err),
    .err_code   (err_code)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // reference model state
  logic [7:0]   exp_q[$];
  logic [7:0]   tx_log[$];
  logic [127:0] exp_res;
  logic [1:0]   exp_code;
  logic         exp_dec;
  bit           job_active = 0;
  int           mstart_count = 0;
  int           res_count = 0;
  int           err_count = 0;

  // SPI master / AES slave model configuration and state
  int           txlen_cfg = 0;
  int           slave_dly = 0;
  bit           slave_en = 1;
  bit           extra_en = 0;
  logic [127:0] res_vec = '0;
  int           xfer_n = 0;
  int           busy_cnt = 0;
  int           wait_cnt = -1;
  int           done_cyc = 0;
  int           last_tx_done_cyc = 0;

  localparam logic [127:0] TEXT_V  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY256  = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
  localparam logic [255:0] KEY128  = 256'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] CT256   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT128   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [255:0] pack(input int start, input int n);
    logic [255:0] r = '0;
    for (int k = 0; k < n; k++) begin
      if (start + k < tx_log.size()) r = (r << 8) | 256'(tx_log[start + k]);
    end
    return r;
  endfunction

  // SPI master + AES slave: each m_start occupies the bus 1..4 cycles and
  // ends in one m_done; after the last frame byte the slave raises
  // s_res_ready after slave_dly cycles, optionally emitting stray m_done.
  initial begin
    m_busy = 1'b0; m_done = 1'b0; m_rx = '0; s_res_ready = 1'b0;
    forever begin
      @(negedge clk);
      m_done = 1'b0;
      if (!reset) begin
        busy_cnt = 0; m_busy = 1'b0; wait_cnt = -1; s_res_ready = 1'b0;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          done_cyc = cyc;
          if (xfer_n >= txlen_cfg) m_rx = res_vec[8*(15-(xfer_n-txlen_cfg)) +: 8];
          else                     m_rx = 8'($urandom);
          xfer_n++;
          if (xfer_n == txlen_cfg) begin
            wait_cnt = slave_dly;
            last_tx_done_cyc = cyc;
          end
        end
      end else if (wait_cnt > 0) begin
        wait_cnt--;
        if (extra_en && (wait_cnt % 3 == 1)) begin
          m_done = 1'b1;
          m_rx = 8'hee;
        end
      end else if (wait_cnt == 0) begin
        if (slave_en) s_res_ready = 1'b1;
        wait_cnt = -1;
      end else if (m_start) begin
        m_busy = 1'b1;
        busy_cnt = $urandom_range(1, 4);
        if (xfer_n >= txlen_cfg) s_res_ready = 1'b0;
      end
    end
  end

  // compare process: every cycle out of reset
  initial forever begin
    @(negedge clk);
    if (reset) begin
      if (m_start) begin
        mstart_count++;
        tx_log.push_back(m_tx);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_m_start: m_tx=%0h with no byte expected", m_tx);
        end else begin
          chk("m_tx", 256'(m_tx), 256'(exp_q.pop_front()));
        end
      end
      if (res_valid) begin
        res_count++;
        chk("res_data", 256'(res_data), 256'(exp_res));
      end
      if (err) begin
        err_count++;
        chk("err_code", 256'(err_code), 256'(exp_code));
      end
      if (job_active) chk("dec_sel", 256'(dec_sel), 256'(exp_dec));
    end
  end

  task automatic setup_job(input logic [127:0] text, input logic [255:0] key,
                           input logic [1:0] ks, input logic dec,
                           input logic [127:0] rv, input int dly,
                           input bit sen, input bit xen);
    int kb;
    kb = (ks == 2'b00) ? 16 : (ks == 2'b01) ? 24 : (ks == 2'b10) ? 32 : 0;
    exp_q.delete();
    if (kb != 0) begin
      for (int i = 15; i >= 0; i--) exp_q.push_back(text[8*i +: 8]);
      exp_q.push_back(8'(kb));
      for (int j = kb - 1; j >= 0; j--) exp_q.push_back(key[8*j +: 8]);
      for (int k = 0; k < 16; k++) exp_q.push_back(8'h00);
    end
    txlen_cfg = (kb != 0) ? 17 + kb : 0;
    exp_res = rv; res_vec = rv; exp_dec = dec;
    exp_code = (kb == 0) ? 2'b01 : 2'b10;
    slave_dly = dly; slave_en = sen; extra_en = xen;
    xfer_n = 0; wait_cnt = -1; s_res_ready = 1'b0;
    tx_log.delete();
    cmd_text = text; cmd_key = key; cmd_ksize = ks; cmd_dec = dec;
  endtask

  task automatic accept(input bit hold);
    int n = 0;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_at_accept", 256'(cmd_ready), 256'(1));
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
    job_active = 1;
  endtask

  task automatic wait_end(input int budget, output int at_cyc);
    int n = 0;
    bit ok = 0;
    while (n < budget) begin
      if (res_valid || err) begin
        ok = 1;
        break;
      end
      @(negedge clk);
      n++;
    end
    at_cyc = cyc;
    job_active = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL job_end: no res_valid or err within %0d cycles", budget);
    end
  endtask

  task automatic run_job(input logic [127:0] text, input logic [255:0] key,
                         input logic [1:0] ks, input logic dec,
                         input logic [127:0] rv, input int dly,
                         input bit xen, input bit hold);
    int r0, e0, m0, endc, nxf;
    setup_job(text, key, ks, dec, rv, dly, 1'b1, xen);
    nxf = (txlen_cfg == 0) ? 0 : txlen_cfg + 16;
    r0 = res_count; e0 = err_count; m0 = mstart_count;
    accept(hold);
    wait_end(3000, endc);
    if (hold) cmd_valid = 1'b0;
    if (ks == 2'b11) begin
      chk("err_pulse", 256'(err), 256'(1));
    end else begin
      chk("res_valid_pulse", 256'(res_valid), 256'(1));
      chk("res_after_last_done", 256'(endc), 256'(done_cyc + 1));
    end
    @(negedge clk);
    chk("cmd_ready_after_job", 256'(cmd_ready), 256'(1));
    chk("res_valid_single", 256'(res_valid), 256'(0));
    chk("res_count", 256'(res_count - r0), 256'((ks == 2'b11) ? 0 : 1));
    chk("err_count", 256'(err_count - e0), 256'((ks == 2'b11) ? 1 : 0));
    chk("m_start_count", 256'(mstart_count - m0), 256'(nxf));
    chk("frame_drained", 256'(exp_q.size()), 256'(0));
  endtask

  initial begin
    int endc, m0, n;
    reset = 1'b0; cmd_valid = 1'b0; cmd_dec = 1'b0; cmd_ksize = '0;
    cmd_text = '0; cmd_key = '0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 256'(cmd_ready), 256'(1));
    chk("rst_outputs", 256'({m_start, res_valid, err, dec_sel, err_code, m_tx}), 256'(0));
    chk("rst_res_data", 256'(res_data), 256'(0));
    reset = 1'b1;
    @(negedge clk);

    // AES-256 vector
    run_job(TEXT_V, KEY256, 2'b10, 1'b0, CT256, 4, 1'b0, 1'b0);
    chk("a256_log_len", 256'(tx_log.size()), 256'(65));
    chk("a256_text_bytes", pack(0, 16), 256'(TEXT_V));
    chk("a256_kb_byte", pack(16, 1), 256'(8'h20));
    chk("a256_key_bytes", pack(17, 32), KEY256);
    chk("a256_rx_zeros", pack(49, 16), 256'(0));
    chk("a256_result", 256'(res_data), 256'(CT256));

    // AES-128 vector
    run_job(TEXT_V, KEY128, 2'b00, 1'b0, CT128, 2, 1'b0, 1'b0);
    chk("a128_log_len", 256'(tx_log.size()), 256'(49));
    chk("a128_kb_byte", pack(16, 1), 256'(8'h10));
    chk("a128_key_bytes", pack(17, 16), KEY128);
    chk("a128_result", 256'(res_data), 256'(CT128));

    // illegal key size
    run_job(TEXT_V, KEY256, 2'b11, 1'b1, CT256, 0, 1'b0, 1'b0);
    chk("ksize_err_code", 256'(err_code), 256'(2'b01));

    // slave never ready -> timeout
    setup_job(TEXT_V, KEY128, 2'b00, 1'b1, CT128, 5, 1'b0, 1'b0);
    accept(1'b0);
    wait_end(3000, endc);
    chk("timeout_err", 256'(err), 256'(1));
    chk("timeout_cycle", 256'(endc), 256'(last_tx_done_cyc + 1 + int'(TMO)));
    @(negedge clk);
    chk("timeout_code_held", 256'(err_code), 256'(2'b10));
    chk("timeout_cmd_ready", 256'(cmd_ready), 256'(1));
    exp_q.delete();

    // reset at byte 20 of an AES-256 job
    setup_job(TEXT_V, KEY256, 2'b10, 1'b1, CT256, 3, 1'b1, 1'b0);
    m0 = mstart_count;
    accept(1'b0);
    n = 0;
    while (mstart_count - m0 < 21 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("reached_byte20", 256'(mstart_count - m0), 256'(21));
    reset = 1'b0;
    job_active = 0;
    @(negedge clk);
    exp_q.delete();
    chk("midrst_cmd_ready", 256'(cmd_ready), 256'(1));
    chk("midrst_outputs", 256'({m_start, res_valid, err, dec_sel, err_code, m_tx}), 256'(0));
    chk("midrst_res_data", 256'(res_data), 256'(0));
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_no_traffic", 256'(mstart_count - m0), 256'(21));
    run_job(TEXT_V, KEY256, 2'b10, 1'b0, CT256, 6, 1'b0, 1'b0);

    // stray m_done in RES_WAIT, cmd_valid held through the job
    run_job(TEXT_V, KEY128, 2'b00, 1'b1, CT128, 14, 1'b1, 1'b1);
    repeat (8) @(negedge clk);

    // randomized jobs
    for (int t = 0; t < 12; t++) begin
      logic [127:0] tx;
      logic [127:0] rv;
      logic [255:0] ky;
      tx = {$urandom, $urandom, $urandom, $urandom};
      rv = {$urandom, $urandom, $urandom, $urandom};
      ky = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_job(tx, ky, 2'($urandom_range(0, 3)), 1'($urandom), rv,
              $urandom_range(0, 20), 1'($urandom), 1'b0);
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
